// File: rtl/uart_tx_framed_if.sv
// uart_tx_framed_if: valid/ready byte-stream handshake between producer and UART transmitter
interface uart_tx_framed_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data_in;
    logic data_in_valid;
    logic data_in_ready;
    modport master (output data_in, output data_in_valid, input data_in_ready);
    modport slave (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: UART transmitter with one-entry holding register, optional parity and 1/2 stop bits
module uart_tx_framed #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS = 1
) (
    input logic clk,
    input logic reset,
    uart_tx_framed_if.slave bus,
    output logic serial_out,
    output logic tx_busy
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] hold, shift, shift_n;
    logic hold_valid, hold_valid_n, par, par_n, serial_n, load, bit_end, accept;

    assign bus.data_in_ready = ~hold_valid;
    assign tx_busy = state != IDLE;
    assign bit_end = clk_cnt == CW'(SYMBOL_EDGE_TIME - 1);
    assign accept = bus.data_in_valid && !hold_valid;

    always_comb begin
        state_n = state;
        bit_cnt_n = bit_cnt;
        shift_n = shift;
        load = 1'b0;
        case (state)
            IDLE: load = hold_valid;
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                shift_n = shift >> 1;
                bit_cnt_n = bit_cnt + 4'd1;
                if (bit_cnt == 4'(DATA_BITS - 1)) begin
                    state_n = PARITY_EN != 0 ? PARITY : STOP;
                    bit_cnt_n = '0;
                end
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP: if (bit_end) begin
                bit_cnt_n = bit_cnt + 4'd1;
                if (bit_cnt == 4'(STOP_BITS - 1)) begin
                    state_n = IDLE;
                    load = hold_valid;
                end
            end
            default: state_n = IDLE;
        endcase
        // a pending byte starts its frame on the same edge the previous one ends
        if (load) begin
            state_n = START;
            shift_n = hold;
            bit_cnt_n = '0;
        end
        clk_cnt_n = (state == IDLE || bit_end) ? '0 : clk_cnt + CW'(1);
        par_n = load ? (^hold) ^ (PARITY_ODD != 0) : par;
        hold_valid_n = accept || (hold_valid && !load);
        serial_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift <= '0;
            hold <= '0;
            hold_valid <= 1'b0;
            par <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            state <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift <= shift_n;
            hold_valid <= hold_valid_n;
            par <= par_n;
            serial_out <= serial_n;
            if (accept) hold <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_uart_tx_framed.sv
// tb_uart_tx_framed: randomized scoreboard bench over 8N1, 8E1, 8O1 and 7N2 transmitters
module tb_uart_tx_framed;
    typedef struct {
        logic [15:0] bits;
        int n;
        int start;
    } exp_t;
    logic clk = 1'b0;
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %0d expected %0d at cycle %0d", lane, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int DB = g == 3 ? 7 : 8;
        localparam int PE = (g == 1 || g == 2) ? 1 : 0;
        localparam int PO = g == 2 ? 1 : 0;
        localparam int SB = g == 3 ? 2 : 1;
        localparam int NB = 1 + DB + PE + SB;
        localparam int L = NB * 10;
        logic rst, sout, busy, fin;
        exp_t q[$];
        uart_tx_framed_if #(.DATA_BITS(DB)) ifc ();
        uart_tx_framed #(
            .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(DB),
            .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
        ) dut (
            .clk(clk), .reset(rst), .bus(ifc), .serial_out(sout), .tx_busy(busy)
        );

        // driver: issues bytes and pushes the frame the line should carry, with its start cycle
        initial begin
            logic [8:0] dl[$];
            int gl[$];
            int abort_at, last_end, t;
            exp_t e;
            fin = 1'b0;
            rst = 1'b1;
            ifc.data_in = '0;
            ifc.data_in_valid = 1'b0;
            #1;
            check("reset_line", g, 32'(sout), 1);
            check("reset_ready", g, 32'(ifc.data_in_ready), 1);
            check("reset_busy", g, 32'(busy), 0);
            @(negedge clk);
            rst = 1'b0;
            if (g == 0) begin
                dl = '{9'h0A5, 9'h055, 9'h00F};
                gl = '{2, 120, 0};
            end else if (g == 3) begin
                dl = '{9'h041};
                gl = '{2};
            end else begin
                dl = '{9'h007};
                gl = '{2};
            end
            for (int k = 0; k < 6; k++) begin
                dl.push_back(9'($urandom));
                gl.push_back($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 150));
            end
            abort_at = -1;
            if (g == 0) begin
                abort_at = dl.size();
                dl.push_back(9'h0C3);
                gl.push_back(30);
                dl.push_back(9'h03C);
                gl.push_back(5);
            end
            last_end = 0;
            foreach (dl[i]) begin
                repeat (gl[i]) @(negedge clk);
                ifc.data_in = dl[i][DB-1:0];
                ifc.data_in_valid = 1'b1;
                t = 0;
                while (!ifc.data_in_ready && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                if (t == 2000) begin
                    ifc.data_in_valid = 1'b0;
                    check("ready_timeout", g, 32'(ifc.data_in_ready), 1);
                    continue;
                end
                @(posedge clk);
                #1;
                ifc.data_in_valid = 1'b0;
                check("ready_after_accept", g, 32'(ifc.data_in_ready), 0);
                e.bits = '0;
                e.n = NB;
                for (int b = 0; b < DB; b++) e.bits[1+b] = dl[i][b];
                if (PE != 0) e.bits[1+DB] = (^dl[i][DB-1:0]) ^ (PO != 0);
                for (int b = 0; b < SB; b++) e.bits[1+DB+PE+b] = 1'b1;
                e.start = cyc + 1 > last_end ? cyc + 1 : last_end;
                last_end = e.start + L;
                q.push_back(e);
                if (i == abort_at) begin
                    while (cyc < e.start + 45) @(negedge clk);
                    #2 rst = 1'b1;
                    #1;
                    check("abort_line", g, 32'(sout), 1);
                    check("abort_busy", g, 32'(busy), 0);
                    check("abort_ready", g, 32'(ifc.data_in_ready), 1);
                    q.delete();
                    last_end = 0;
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                end
            end
            t = 0;
            while ((q.size() != 0 || cyc <= last_end + 2) && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t == 5000) check("drain_timeout", g, 32'(q.size()), 0);
            fin = 1'b1;
        end

        // monitor: detects start bits and checks each bit over its full 10-cycle window
        initial begin
            exp_t m;
            logic ok, aborted, just_ended;
            just_ended = 1'b0;
            forever begin
                @(negedge clk);
                if (just_ended && sout === 1'b1 && !rst) check("idle_busy", g, 32'(busy), 0);
                just_ended = 1'b0;
                if (!rst && sout === 1'b0) begin
                    check("start_expected", g, 32'(q.size() > 0), 1);
                    if (q.size() == 0) begin
                        for (int c = 0; c < 200 && sout === 1'b0; c++) @(negedge clk);
                    end else begin
                        m = q.pop_front();
                        check("start_cycle", g, 32'(cyc), 32'(m.start));
                        aborted = 1'b0;
                        for (int b = 0; b < m.n && !aborted; b++) begin
                            ok = 1'b1;
                            for (int c = 0; c < 10; c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (rst) begin
                                    aborted = 1'b1;
                                    break;
                                end
                                if (sout !== m.bits[b] || busy !== 1'b1) ok = 1'b0;
                            end
                            if (!aborted) check($sformatf("frame_bit%0d_held_as_%0d", b, m.bits[b]), g, 32'(ok), 1);
                        end
                        just_ended = !aborted;
                    end
                end
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        if (t == 60000) check("global_timeout", -1, 32'({lane[3].fin, lane[2].fin, lane[1].fin, lane[0].fin}), 15);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_framed.md
Name: uart_tx_framed

Overview:
Parametrised UART transmitter, next generation of the lab UART TX path. Supports configurable data width, optional even/odd parity and 1 or 2 stop bits. A one-entry holding register lets back-to-back bytes go out with no idle gap between frames. Sits between the byte-stream producer (FIFO or echo logic) and the board TX pin.

Parameters:
CLOCK_FREQ, 125_000_000, clk frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s; SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division) clk cycles per bit
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, valid only when PARITY_EN=1; 0 = even parity, 1 = odd parity
STOP_BITS, 1, number of stop bits, legal 1 or 2

Ports:
clk  input  1  system clock; all state on posedge clk
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_BITS  byte to send, LSB first on line
data_in_valid  input  1  producer has data_in
data_in_ready  output  1  holding register empty; transfer on valid && ready at posedge
serial_out  output  1  UART line, idle high, registered
tx_busy  output  1  frame engine not in IDLE

Behaviour:
- Reset (async assert, sync deassert by the integrator): serial_out=1, tx_busy=0, data_in_ready=1, holding register empty, bit/clock counters 0, state IDLE. Reset mid-frame aborts immediately; line returns high with no partial stop bit.
- Handshake: data_in_ready = ~hold_valid (register-driven, no combinational path from data_in_valid). On valid && ready at edge N, data_in is captured into hold and hold_valid=1. data_in is ignored when ready=0; the producer holds it stable.
- Frame: start(0), DATA_BITS data bits LSB first, [parity], STOP_BITS stop bits(1). Every bit is held exactly SYMBOL_EDGE_TIME cycles on serial_out.
- Parity: even = XOR of all data bits; odd = its inverse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial_out=1. If hold_valid at an edge, load the shift register from hold, clear hold_valid, go to START; serial_out=0 from that edge.
  - START -> DATA after SYMBOL_EDGE_TIME cycles.
  - DATA: shift out DATA_BITS bits, then go to PARITY if PARITY_EN, else STOP.
  - PARITY -> STOP after one bit time.
  - STOP: after STOP_BITS bit times, if hold_valid, load and go directly to START at the same edge (zero idle cycles between frames). Otherwise go to IDLE.
- Latency: accept at edge N, start bit driven from edge N+1 when idle.
- Throughput: hold is refilled while a frame is in flight, so a continuous stream produces contiguous frames.
- Simultaneous events: an edge where hold is loaded into the engine and the producer presents data cannot accept, because ready is low at that edge. Acceptance occurs at the next edge.
- Counters: clock counter width is $clog2(SYMBOL_EDGE_TIME+1) and runs 0..SYMBOL_EDGE_TIME-1, wrapping at each bit boundary. Bit counter width is 4.
- tx_busy=1 in every state except IDLE. Frame length = 1 + DATA_BITS + PARITY_EN + STOP_BITS bit times.

Test Plan:
All tests use CLOCK_FREQ=1000, BAUD_RATE=100 (10 cycles/bit).
- Reset: assert reset with clk stopped -> serial_out=1, data_in_ready=1, tx_busy=0 immediately.
- 8N1 single byte 0xA5, accepted at edge N -> serial_out from edge N+1 is 0,1,0,1,0,0,1,0,1,1, each exactly 10 cycles. Then idle high, tx_busy=0 at edge N+101.
- Back-to-back 0x55 then 0x0F with valid held high -> second start bit immediately follows the first stop bit (zero gap). data_in_ready low except one cycle after each engine load.
- PARITY_EN=1 with data 0x07: PARITY_ODD=0 -> parity bit 1; PARITY_ODD=1 -> parity bit 0. Frame is 11 bit times.
- STOP_BITS=2, DATA_BITS=7, data 0x41 -> frame 0,1,0,0,0,0,0,1,1,1, total 100 cycles before the next start.
- Reset asserted during the 4th data bit -> serial_out=1 at once. After release, a new byte 0x3C is sent as a clean full frame.
